// File: rtl/imem_host_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_host_arbiter_if
// Description : Wishbone slave-side bus bundle for the imem host arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_host_arbiter_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface
`default_nettype wire

// File: rtl/imem_host_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_host_arbiter
// Description : Wishbone slave owning the core reset and sharing the imem
//               between the core fetch port and the management SoC.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_host_arbiter #(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
    parameter int          IMEM_AW   = 8,
    parameter int          IMEM_DW   = 8
) (
    input  wire logic               wb_clk_i,
    input  wire logic               wb_rst_i,
    imem_host_arbiter_if.slave      wbs,
    output logic                    cpu_rst_o,
    output logic                    cpu_stall_o,
    input  wire logic [IMEM_AW-1:0] cpu_imem_addr_i,
    output logic [IMEM_DW-1:0]      cpu_imem_rdata_o,
    output logic [IMEM_AW-1:0]      imem_addr_o,
    output logic [IMEM_DW-1:0]      imem_wdata_o,
    output logic                    imem_we_o,
    input  wire logic [IMEM_DW-1:0] imem_rdata_i
);

    localparam logic [15:0] C_OFF_CTRL   = 16'h0000;
    localparam logic [15:0] C_OFF_STATUS = 16'h0004;
    localparam logic [15:0] C_OFF_CYCLES = 16'h0008;
    localparam logic [15:0] C_OFF_IMEM   = 16'h1000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STALL  = 3'd1,
        S_ACCESS = 3'd2,
        S_RDWAIT = 3'd3,
        S_ACK    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 run_q;
    logic [31:0]          cycles_q;
    logic [31:0]          dat_q;
    logic [IMEM_AW-1:0]   addr_q;
    logic [IMEM_DW-1:0]   wdata_q;
    logic                 we_q;
    logic                 sel0_q;
    logic                 ctrl_wr_q;

    logic                 w_req;
    logic                 w_imem_hit;
    logic [15:0]          w_off;
    logic [31:0]          w_reg_rdata;
    logic                 w_run_rise;
    logic                 w_unused;

    assign w_off      = wbs.wbs_adr_i[15:0];
    assign w_req      = wbs.wbs_cyc_i && wbs.wbs_stb_i
                        && (wbs.wbs_adr_i[31:16] == ADDR_BASE[31:16]);
    assign w_imem_hit = (w_off[15:IMEM_AW+2] == C_OFF_IMEM[15:IMEM_AW+2])
                        && (w_off[1:0] == 2'b00);
    assign w_unused   = ^{wbs.wbs_sel_i[3:1], wbs.wbs_dat_i[31:IMEM_DW]};

    always_comb begin
        w_reg_rdata = 32'h0;
        if (!wbs.wbs_we_i) begin
            case (w_off)
                C_OFF_CTRL:   w_reg_rdata = {31'h0, run_q};
                C_OFF_STATUS: w_reg_rdata = {30'h0, cpu_stall_o, run_q};
                C_OFF_CYCLES: w_reg_rdata = cycles_q;
                default:      w_reg_rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        imem_addr_o  = cpu_imem_addr_i;
        imem_we_o    = 1'b0;
        imem_wdata_o = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (w_req) begin
                    if (w_imem_hit) begin
                        state_d = run_q ? S_STALL : S_ACCESS;
                    end else begin
                        state_d = S_ACK;
                    end
                end
            end
            S_STALL:  state_d = S_ACCESS;
            S_ACCESS: begin
                imem_addr_o = addr_q;
                if (we_q) begin
                    imem_we_o = sel0_q;
                    state_d   = S_ACK;
                end else begin
                    state_d   = S_RDWAIT;
                end
            end
            S_RDWAIT: state_d = S_ACK;
            S_ACK:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // RUN is applied on the edge leaving ACK so it never changes under an ack.
    assign w_run_rise = (state_q == S_ACK) && ctrl_wr_q && wdata_q[0] && !run_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            run_q     <= 1'b0;
            cycles_q  <= 32'h0;
            dat_q     <= 32'h0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            sel0_q    <= 1'b0;
            ctrl_wr_q <= 1'b0;
        end else begin
            if (w_run_rise) begin
                cycles_q <= 32'h0;
            end else if (run_q && !cpu_stall_o) begin
                cycles_q <= cycles_q + 32'h1;
            end
            case (state_q)
                S_IDLE: begin
                    if (w_req) begin
                        addr_q    <= wbs.wbs_adr_i[IMEM_AW+1:2];
                        wdata_q   <= wbs.wbs_dat_i[IMEM_DW-1:0];
                        we_q      <= wbs.wbs_we_i;
                        sel0_q    <= wbs.wbs_sel_i[0];
                        ctrl_wr_q <= wbs.wbs_we_i && wbs.wbs_sel_i[0]
                                     && (w_off == C_OFF_CTRL);
                        dat_q     <= w_reg_rdata;
                    end
                end
                S_RDWAIT: dat_q <= {{(32-IMEM_DW){1'b0}}, imem_rdata_i};
                S_ACK: begin
                    if (ctrl_wr_q) begin
                        run_q <= wdata_q[0];
                    end
                    ctrl_wr_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign cpu_rst_o        = !run_q;
    assign cpu_stall_o      = run_q && ((state_q == S_STALL) || (state_q == S_ACCESS)
                                        || (state_q == S_RDWAIT));
    assign cpu_imem_rdata_o = imem_rdata_i;
    assign wbs.wbs_ack_o    = (state_q == S_ACK);
    assign wbs.wbs_dat_o    = (state_q == S_ACK) ? dat_q : 32'h0;

endmodule
`default_nettype wire
